// File: rtl/systolic_result_streamer.sv
// systolic_result_streamer: starts systolic_array_top, bounds the wait for done, then streams result_flat row-major
//   cmd_start/cmd_ready          : command handshake, ready only in IDLE
//   array_start                  : one-cycle start pulse to the array
//   computation_done/result_valid: completion status from the array
//   result_flat                  : N*N results, element (i,j) at bit (i*N+j)*ACCUMULATOR_WIDTH
//   out_*                        : valid/ready element stream with row/col indices and last flag
//   stream_done                  : one-cycle pulse after the final handshake
//   err_timeout/err_invalid      : sticky until the next accepted command
module systolic_result_streamer #(
  parameter int ARRAY_SIZE        = 64,
  parameter int ACCUMULATOR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES    = 10000
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               cmd_start,
  output logic                                               cmd_ready,
  output logic                                               array_start,
  input  logic                                               computation_done,
  input  logic                                               result_valid,
  input  logic [ACCUMULATOR_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0] result_flat,
  output logic [ACCUMULATOR_WIDTH-1:0]                       out_data,
  output logic [(ARRAY_SIZE>1 ? $clog2(ARRAY_SIZE) : 1)-1:0] out_row,
  output logic [(ARRAY_SIZE>1 ? $clog2(ARRAY_SIZE) : 1)-1:0] out_col,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic                                               out_last,
  output logic                                               stream_done,
  output logic                                               err_timeout,
  output logic                                               err_invalid
);
  localparam int IW = ARRAY_SIZE > 1 ? $clog2(ARRAY_SIZE) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] MAX_IDX = IW'(ARRAY_SIZE - 1);
  typedef enum logic [1:0] {IDLE, WAIT_DONE, STREAM} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] nr, nc;
  logic [ACCUMULATOR_WIDTH-1:0] nxt_data;
  always_comb begin
    nc = out_col == MAX_IDX ? '0 : out_col + 1'b1;
    nr = out_col == MAX_IDX ? out_row + 1'b1 : out_row;
    nxt_data = result_flat[(int'(nr) * ARRAY_SIZE + int'(nc)) * ACCUMULATOR_WIDTH +: ACCUMULATOR_WIDTH];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd_ready   <= 1'b1;
      array_start <= 1'b0;
      out_data    <= '0;
      out_row     <= '0;
      out_col     <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      stream_done <= 1'b0;
      err_timeout <= 1'b0;
      err_invalid <= 1'b0;
    end else begin
      array_start <= 1'b0;
      stream_done <= 1'b0;
      case (state)
        IDLE: if (cmd_start) begin
          state       <= WAIT_DONE;
          cmd_ready   <= 1'b0;
          array_start <= 1'b1;
          cnt         <= '0;
          err_timeout <= 1'b0;
          err_invalid <= 1'b0;
        end
        WAIT_DONE: begin
          cnt <= cnt + 1'b1;
          // a done seen while array_start is still high belongs to the previous run
          if (computation_done && !array_start) begin
            if (result_valid) begin
              state     <= STREAM;
              out_valid <= 1'b1;
              out_row   <= '0;
              out_col   <= '0;
              out_data  <= result_flat[ACCUMULATOR_WIDTH-1:0];
              out_last  <= ARRAY_SIZE == 1;
            end else begin
              state       <= IDLE;
              cmd_ready   <= 1'b1;
              err_invalid <= 1'b1;
            end
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            err_timeout <= 1'b1;
          end
        end
        STREAM: if (out_ready) begin
          if (out_last) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            stream_done <= 1'b1;
          end else begin
            out_row  <= nr;
            out_col  <= nc;
            out_data <= nxt_data;
            out_last <= nr == MAX_IDX && nc == MAX_IDX;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_result_streamer.sv
// tb_systolic_result_streamer: randomized self-checking bench against an index-based stream model
module tb_systolic_result_streamer;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 50;
  localparam int NN = N * N;
  logic clk = 1'b0, rst = 1'b1, cmd_start = 1'b0, computation_done = 1'b0, result_valid = 1'b0, out_ready = 1'b0;
  logic [W*NN-1:0] result_flat = '0;
  logic cmd_ready, array_start, out_valid, out_last, stream_done, err_timeout, err_invalid;
  logic [W-1:0] out_data;
  logic [1:0] out_row, out_col;
  logic [W-1:0] mat [NN];
  int checks = 0, failures = 0;
  systolic_result_streamer #(.ARRAY_SIZE(N), .ACCUMULATOR_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_ready(cmd_ready), .array_start(array_start),
    .computation_done(computation_done), .result_valid(result_valid), .result_flat(result_flat),
    .out_data(out_data), .out_row(out_row), .out_col(out_col), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .stream_done(stream_done), .err_timeout(err_timeout), .err_invalid(err_invalid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic set_mat(input bit ramp);
    for (int i = 0; i < NN; i++) begin
      mat[i] = ramp ? W'((i / N) * 16 + i % N) : W'($urandom);
      result_flat[i*W +: W] = mat[i];
    end
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdy"}, W'(cmd_ready), 1);
    chk({tag, "_outs"}, W'({out_valid, array_start, out_last, stream_done, err_timeout, err_invalid}), 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_rc"}, W'({out_row, out_col}), 0);
  endtask
  // dly: done is driven at wait cycle dly, i.e. sampled dly+1 edges after cmd_start was taken
  // rmode: 0 ready always, 1 pattern 1,0,0,1, 2 random; rst_beat: beat index at which reset hits, -1 none
  task automatic op(input int dly, input bit rv, input bit nodone, input bit stale, input int rmode, input int rst_beat);
    int k, idx, pc;
    bit fin;
    @(negedge clk);
    chk("idle_rdy", W'(cmd_ready), 1);
    chk("sdone_pulse", W'(stream_done), 0);
    cmd_start = 1'b1;
    result_valid = rv;
    computation_done = stale;
    out_ready = 1'b0;
    @(negedge clk);
    cmd_start = 1'b0;
    chk("astart", W'(array_start), 1);
    chk("busy", W'(cmd_ready), 0);
    chk("err_clr", W'({err_timeout, err_invalid}), 0);
    computation_done = stale || (!nodone && dly == 0);
    k = 0; idx = 0; pc = 0; fin = 1'b0;
    while (!fin && k < 400) begin
      @(negedge clk);
      k++;
      chk("astart_once", W'(array_start), 0);
      if (nodone) begin
        chk("to_flag", W'(err_timeout), W'(k >= TO));
        chk("to_noval", W'(out_valid), 0);
        if (k == TO) begin
          chk("to_idle", W'(cmd_ready), 1);
          fin = 1'b1;
        end
      end else if (k <= dly) begin
        chk(stale && k == 1 ? "stale_ign" : "wait", W'({out_valid, cmd_ready, err_invalid, err_timeout}), 0);
      end else if (!rv) begin
        chk("inv_flag", W'(err_invalid), 1);
        chk("inv_idle", W'({cmd_ready, out_valid}), 2);
        fin = 1'b1;
      end else if (idx == NN) begin
        chk("end_done", W'(stream_done), 1);
        chk("end_idle", W'({cmd_ready, out_valid, out_last}), 4);
        fin = 1'b1;
      end else begin
        chk("valid", W'({out_valid, stream_done, err_timeout}), 4);
        chk("data", out_data, mat[idx]);
        chk("row", W'(out_row), W'(idx / N));
        chk("col", W'(out_col), W'(idx % N));
        chk("last", W'(out_last), W'(idx == NN - 1));
        if (idx == rst_beat) begin
          #2 rst = 1'b1;
          #1 check_reset_outputs("mid_rst");
          computation_done = 1'b0;
          out_ready = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          return;
        end
      end
      computation_done = !nodone && k == dly;
      if (!fin && !nodone && rv && k > dly && idx < NN) begin
        out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (pc % 4 == 0 || pc % 4 == 3) : 1'($urandom_range(0, 1));
        pc++;
        if (out_ready) idx++;
      end else out_ready = 1'b0;
    end
    if (!fin) chk("op_bound", 0, 1);
    computation_done = 1'b0;
    out_ready = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("in_rst");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_rst");
    set_mat(1'b1);
    op(19, 1'b1, 1'b0, 1'b0, 0, -1);
    op(19, 1'b1, 1'b0, 1'b0, 1, -1);
    op(5, 1'b1, 1'b1, 1'b0, 0, -1);
    op(19, 1'b1, 1'b0, 1'b0, 0, -1);
    op(TO - 1, 1'b1, 1'b0, 1'b0, 0, -1);
    op(10, 1'b1, 1'b0, 1'b1, 0, -1);
    op(7, 1'b0, 1'b0, 1'b0, 0, -1);
    op(1, 1'b1, 1'b0, 1'b0, 2, -1);
    op(19, 1'b1, 1'b0, 1'b0, 0, 7);
    op(19, 1'b1, 1'b0, 1'b0, 0, -1);
    for (int r = 0; r < 8; r++) begin
      int d;
      set_mat(1'b0);
      d = $urandom_range(1, 30);
      op(d, 1'($urandom_range(0, 5) != 0), 1'b0, d >= 2 && 1'($urandom_range(0, 1)), 2, -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/systolic_result_streamer.md
# systolic_result_streamer

Command-side initiator and result drain for `systolic_array_top`. It accepts a compute command, pulses the array's `start`, waits for `computation_done`, and bounds that wait with a timeout. It then reads the flattened `result_flat` bus and emits it one element per handshake on a valid/ready stream, row-major. The host side no longer needs to extract the full ARRAY_SIZE² bus itself.

## Interface
- ARRAY_SIZE, 64, matrix dimension N; stream length is N*N
- ACCUMULATOR_WIDTH, 32, width of each result element
- TIMEOUT_CYCLES, 10000, maximum WAIT_DONE cycles before abort; minimum 2
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_start  in  1  request one computation; accepted only when cmd_ready=1
- cmd_ready  out  1  high only in IDLE
- array_start  out  1  one-cycle pulse to systolic_array_top.start
- computation_done  in  1  from array
- result_valid  in  1  from array
- result_flat  in  ACCUMULATOR_WIDTH*N*N  from array; element (i,j) at bit (i*N+j)*ACCUMULATOR_WIDTH
- out_data  out  ACCUMULATOR_WIDTH  current element
- out_row, out_col  out  $clog2(N) each  indices of out_data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_last  out  1  high with element (N-1,N-1)
- stream_done  out  1  one-cycle pulse after the last handshake
- err_timeout  out  1  sticky; the wait exceeded TIMEOUT_CYCLES
- err_invalid  out  1  sticky; computation_done was seen with result_valid=0

## Operation
- FSM states:
  - IDLE
    - cmd_ready=1.
    - cmd_start=1 at an edge: go to WAIT_DONE, set array_start=1 for the next cycle only, clear wait counter, clear err_timeout and err_invalid.
  - WAIT_DONE
    - Wait counter increments every cycle.
    - computation_done is ignored in the cycle array_start is high. This guards against a stale done from the previous operation.
    - Otherwise, computation_done=1 with result_valid=1: go to STREAM with idx=0, load element 0.
    - computation_done=1 with result_valid=0: set err_invalid, go to IDLE.
    - Counter reaches TIMEOUT_CYCLES-1 without done: set err_timeout, go to IDLE.
    - Done and timeout on the same edge: done wins.
  - STREAM
    - out_valid=1.
    - Each handshake (out_valid & out_ready) increments idx and loads the next element.
    - Handshake with idx=N*N-1: go to IDLE, pulse stream_done, drop out_valid.
- idx runs 0..N*N-1, with out_row=idx/N and out_col=idx%N. Implement as row/col counters; col wraps at N-1 and increments row.
- out_data, out_row, out_col and out_last are registered. They hold stable while out_valid=1 and out_ready=0.
- cmd_start outside IDLE is ignored, with no queueing.
- result_flat must remain stable from done until stream_done. The array holds it until its next start, and no start is issued before IDLE.

## Timing
- Reset values (async, immediate): state=IDLE, cmd_ready=1, all other outputs 0, including out_data, out_row, out_col and both error flags.
- cmd_start sampled at edge T:
  - array_start high in cycle T..T+1.
  - Earliest done sample is edge T+2.
- Done sampled at edge D: out_valid=1 with element (0,0) from D, i.e. 1-cycle latency.
- With out_ready held high, one element per cycle:
  - last handshake at edge D+N*N;
  - stream_done high during the following cycle;
  - cmd_ready=1 in the same cycle, so a new cmd_start is accepted there.
- Timeout: err_timeout rises TIMEOUT_CYCLES cycles after array_start first rises.
- rst asserted mid-stream: out_valid drops immediately and the in-flight transfer is abandoned. The array is not re-started until a new cmd_start.

## Test plan
- Reset: rst held 3 cycles, then released → cmd_ready=1, out_valid=0, array_start=0, both error flags 0.
- N=4 nominal, result element (i,j)=i*16+j, array model asserts done 20 cycles after start, out_ready=1:
  - 16 beats, values 0x00,0x01,…,0x33 in order;
  - out_last only on 0x33;
  - stream_done one cycle later;
  - exactly one array_start pulse.
- Backpressure, N=4, out_ready toggling 1,0,0,1 → out_data/out_row/out_col frozen during ready=0, no element dropped or duplicated, same 16-value sequence.
- Timeout, TIMEOUT_CYCLES=50, done never asserted → err_timeout=1 exactly 50 cycles after array_start rise, return to IDLE, out_valid never high. A following successful cmd_start clears err_timeout.
- Stale done and error:
  - computation_done held high across cmd_start → ignored in the array_start cycle, no early stream.
  - done=1 with result_valid=0 → err_invalid=1, IDLE.
- Reset mid-stream at beat 7 of 16 → outputs at reset values within the same cycle. A new cmd_start restarts at (0,0).
